// File: rtl/inport_debounce.sv
// rtl/inport_debounce.sv - two-channel input port: synchronize, debounce, hold with valid/overrun (optional: INPORT_OVERRUN_EN)
module inport_debounce #(
    parameter int DW        = 4,
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] ext_in1,
    input  logic [DW-1:0] ext_in2,
    input  logic          Reg1RD,
    input  logic          Reg2RD,
    output logic [DW-1:0] Reg1_in,
    output logic [DW-1:0] Reg2_in,
    output logic          Reg1_valid,
    output logic          Reg2_valid,
    output logic          Reg1_ovr,
    output logic          Reg2_ovr
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic [1:0][DW-1:0]    raw;
    logic [1:0]            rd;
    logic [1:0][DW-1:0]    s1_q, s1_d, s2_q, s2_d;
    logic [1:0][DW-1:0]    cand_q, cand_d, stable_q, stable_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            valid_q, valid_d;
    logic [1:0]            accept;

    assign raw = {ext_in2, ext_in1};
    assign rd  = {Reg2RD, Reg1RD};

    always_comb begin
        s1_d     = raw;
        s2_d     = s1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        valid_d  = valid_q;
        accept   = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != cand_q[i]) begin
                cand_d[i] = s2_q[i];
                cnt_d[i]  = '0;
            end else if (cnt_q[i] < CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
            // Only a qualified value that differs from the held one is accepted
            accept[i] = (s2_q[i] == cand_q[i]) && (cnt_q[i] == CNT_MAX)
                        && (cand_q[i] != stable_q[i]);
            if (accept[i]) begin
                stable_d[i] = cand_q[i];
                valid_d[i]  = 1'b1;
            end else if (rd[i]) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
            valid_q  <= '0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            valid_q  <= valid_d;
        end
    end

    assign Reg1_in    = stable_q[0];
    assign Reg2_in    = stable_q[1];
    assign Reg1_valid = valid_q[0];
    assign Reg2_valid = valid_q[1];

`ifdef INPORT_OVERRUN_EN
    logic [1:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        for (int i = 0; i < 2; i++) begin
            if (accept[i] && valid_q[i] && !rd[i]) begin
                ovr_d[i] = 1'b1;
            end else if (rd[i]) begin
                ovr_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign Reg1_ovr = ovr_q[0];
    assign Reg2_ovr = ovr_q[1];
`else
    assign Reg1_ovr = 1'b0;
    assign Reg2_ovr = 1'b0;
`endif

endmodule

// File: tb/tb_inport_debounce.sv
// tb/tb_inport_debounce.sv - directed and random checks of inport_debounce against a sample-window model
module tb_inport_debounce;

    localparam int DB   = 16;
    localparam int HLEN = 8192;
`ifdef INPORT_OVERRUN_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] ext_in1 = '0, ext_in2 = '0;
    logic       Reg1RD = 1'b0, Reg2RD = 1'b0;
    logic [3:0] Reg1_in, Reg2_in;
    logic       Reg1_valid, Reg2_valid, Reg1_ovr, Reg2_ovr;

    int tests = 0;
    int fails = 0;
    int edge_n = 32;

    // hist[c][e] = raw value sampled at edge e; -1 marks a break in the run
    int         hist [2][HLEN];
    logic [3:0] m_stable [2];
    bit         m_valid [2];
    bit         m_ovr [2];

    inport_debounce dut (
        .clk(clk), .rst(rst),
        .ext_in1(ext_in1), .ext_in2(ext_in2),
        .Reg1RD(Reg1RD), .Reg2RD(Reg2RD),
        .Reg1_in(Reg1_in), .Reg2_in(Reg2_in),
        .Reg1_valid(Reg1_valid), .Reg2_valid(Reg2_valid),
        .Reg1_ovr(Reg1_ovr), .Reg2_ovr(Reg2_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // A value is accepted once it has been sampled unchanged DB+1 times,
    // seen through the two-edge synchronizer delay.
    task automatic model_edge(input int c, input logic [3:0] x, input bit rdc);
        bit acc;
        int v;
        if (!rst) begin
            hist[c][edge_n]     = 0;
            hist[c][edge_n - 1] = 0;
            hist[c][edge_n - 2] = 0;
            hist[c][edge_n - 3] = -1;
            m_stable[c] = '0;
            m_valid[c]  = 1'b0;
            m_ovr[c]    = 1'b0;
        end else begin
            hist[c][edge_n] = int'(x);
            v   = hist[c][edge_n - 2];
            acc = (v >= 0) && (v != int'(m_stable[c]));
            for (int k = 0; k <= DB; k++)
                if (hist[c][edge_n - 2 - k] != v) acc = 1'b0;
            if (OVR_ON) begin
                if (acc && m_valid[c] && !rdc) m_ovr[c] = 1'b1;
                else if (rdc)                  m_ovr[c] = 1'b0;
            end
            if (acc) begin
                m_stable[c] = v[3:0];
                m_valid[c]  = 1'b1;
            end else if (rdc) begin
                m_valid[c] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (edge_n >= HLEN) begin
            $display("FAIL history_overflow observed=%0d expected<%0d", edge_n, HLEN);
            $fatal(1);
        end
        model_edge(0, ext_in1, Reg1RD);
        model_edge(1, ext_in2, Reg2RD);
        #1;
        chk("reg1_in",    Reg1_in,    m_stable[0]);
        chk("reg2_in",    Reg2_in,    m_stable[1]);
        chk("reg1_valid", {3'b0, Reg1_valid}, {3'b0, m_valid[0]});
        chk("reg2_valid", {3'b0, Reg2_valid}, {3'b0, m_valid[1]});
        chk("reg1_ovr",   {3'b0, Reg1_ovr},   {3'b0, m_ovr[0]});
        chk("reg2_ovr",   {3'b0, Reg2_ovr},   {3'b0, m_ovr[1]});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_both();
        Reg1RD = 1'b1; Reg2RD = 1'b1;
        tick();
        Reg1RD = 1'b0; Reg2RD = 1'b0;
    endtask

    int hold [2];

    initial begin
        for (int c = 0; c < 2; c++) begin
            for (int e = 0; e < HLEN; e++) hist[c][e] = -1;
            m_stable[c] = '0; m_valid[c] = 1'b0; m_ovr[c] = 1'b0;
        end
        #1;

        // Reset and idle
        rst = 1'b0; ext_in1 = 4'h7;
        ticks(3);
        chk("rst_reg1_in", Reg1_in, 4'h0);
        chk("rst_reg1_valid", {3'b0, Reg1_valid}, 4'h0);
        rst = 1'b1; ext_in1 = 4'h0;
        ticks(40);
        chk("idle_reg1_valid", {3'b0, Reg1_valid}, 4'h0);

        // Clean change: accepted exactly at edge DB+3
        ext_in1 = 4'h4; ext_in2 = 4'h8;
        ticks(DB + 2);
        chk("early_reg1_valid", {3'b0, Reg1_valid}, 4'h0);
        chk("early_reg2_valid", {3'b0, Reg2_valid}, 4'h0);
        tick();
        chk("lat_reg1_valid", {3'b0, Reg1_valid}, 4'h1);
        chk("lat_reg1_in", Reg1_in, 4'h4);
        chk("lat_reg2_in", Reg2_in, 4'h8);
        ticks(5);

        // Read clears only its own channel
        Reg1RD = 1'b1; tick(); Reg1RD = 1'b0;
        chk("rd_reg1_valid", {3'b0, Reg1_valid}, 4'h0);
        chk("rd_reg1_in", Reg1_in, 4'h4);
        chk("rd_reg2_valid", {3'b0, Reg2_valid}, 4'h1);
        read_both();

        // Bounce, then settle at 5
        for (int s = 0; s < 12; s++) begin
            ext_in1 = (s % 2 == 0) ? 4'h5 : 4'h4;
            ticks(5);
        end
        ext_in1 = 4'h5;
        ticks(DB + 2);
        chk("bounce_reg1_in", Reg1_in, 4'h4);
        tick();
        chk("settle_reg1_in", Reg1_in, 4'h5);
        ticks(3);

        // Read on the same edge as a new accept: set wins
        read_both();
        ext_in1 = 4'h9;
        ticks(DB + 2);
        Reg1RD = 1'b1; tick(); Reg1RD = 1'b0;
        chk("setwin_reg1_valid", {3'b0, Reg1_valid}, 4'h1);
        chk("setwin_reg1_in", Reg1_in, 4'h9);

        // Overrun
        read_both();
        ext_in1 = 4'h3; ticks(25);
        ext_in1 = 4'h6; ticks(25);
        chk("ovr_reg1_in", Reg1_in, 4'h6);
        chk("ovr_reg1_ovr", {3'b0, Reg1_ovr}, {3'b0, OVR_ON});
        Reg1RD = 1'b1; tick(); Reg1RD = 1'b0;
        chk("ovrclr_reg1_ovr", {3'b0, Reg1_ovr}, 4'h0);
        chk("ovrclr_reg1_valid", {3'b0, Reg1_valid}, 4'h0);

        // Reset in the middle of a debounce
        ext_in1 = 4'hA; ticks(10);
        rst = 1'b0; tick();
        chk("midrst_reg1_in", Reg1_in, 4'h0);
        chk("midrst_reg2_in", Reg2_in, 4'h0);
        rst = 1'b1;
        ticks(DB + 2);
        chk("relq_reg1_valid", {3'b0, Reg1_valid}, 4'h0);
        tick();
        chk("rel_reg1_valid", {3'b0, Reg1_valid}, 4'h1);
        chk("rel_reg1_in", Reg1_in, 4'hA);

        // Random phase
        hold[0] = 0; hold[1] = 0;
        for (int n = 0; n < 1500; n++) begin
            if (hold[0] == 0) begin ext_in1 = 4'($urandom_range(0, 15)); hold[0] = $urandom_range(1, 25); end
            if (hold[1] == 0) begin ext_in2 = 4'($urandom_range(0, 15)); hold[1] = $urandom_range(1, 25); end
            hold[0]--; hold[1]--;
            Reg1RD = ($urandom_range(0, 9) == 0);
            Reg2RD = ($urandom_range(0, 9) == 0);
            rst    = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inport_debounce.md
Name: inport_debounce

Overview:
- Input-side counterpart of the processor's output port block.
- Two independent 4-bit external input channels (switches/keypad nibbles).
- Each channel is synchronized, debounced and held in a stable register with a valid flag.
- The CPU consumes a channel's value with a one-cycle read strobe, which clears that channel's valid flag.

Parameters:
- DW, 4: width of each input channel and each held value.
- DB_CYCLES, 16: consecutive cycles the synchronized input must be unchanged before it is accepted; minimum 2.
- CNT_W, 5: debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- ext_in1  input  DW  raw asynchronous external input, channel 1.
- ext_in2  input  DW  raw asynchronous external input, channel 2.
- Reg1RD  input  1  CPU read strobe, channel 1; one cycle high per read.
- Reg2RD  input  1  CPU read strobe, channel 2.
- Reg1_in  output  DW  debounced stable value, channel 1.
- Reg2_in  output  DW  debounced stable value, channel 2.
- Reg1_valid  output  1  new unread stable value present, channel 1.
- Reg2_valid  output  1  new unread stable value present, channel 2.
- Reg1_ovr  output  1  overrun flag, channel 1 (see Optional Feature).
- Reg2_ovr  output  1  overrun flag, channel 2.

Behaviour:
- Reset (rst==0 at a clock edge): all registers cleared.
  - s1, s2, cand, cnt, stable, valid and ovr go to 0 on both channels.
  - Reg*_in=0, Reg*_valid=0, Reg*_ovr=0.
  - Reset mid-debounce discards the partial count; inputs are re-qualified from scratch after reset.
- Channels are identical and fully independent; below, x = 1 or 2.
- Synchronizer: s1 <= ext_inx; s2 <= s1. Two flops, no logic between them.
- Debounce:
  - If s2 != cand: cand <= s2 and cnt <= 0.
  - Else if cnt < DB_CYCLES-1: cnt <= cnt+1. The counter saturates at DB_CYCLES-1.
- Accept: if s2==cand, cnt==DB_CYCLES-1 and cand != stable, then stable <= cand and valid <= 1.
- Acceptance fires only on a value change. A constant input never re-asserts valid.
- Latency: with ext_inx changed before edge 1 and held constant, Reg*_in and valid update at edge DB_CYCLES+3 (edge 19 at default).
- Glitches: any input bounce shorter than DB_CYCLES+1 cycles restarts the counter and is never accepted.
- Read: RegxRD==1 at an edge clears valid. Reg*_in keeps its value until the next accepted change.
- RegxRD while valid==0 has no effect.
- Simultaneous accept and read on the same edge: set wins. valid stays 1 and Reg*_in takes the new value.
- A new accept while valid==1 overwrites stable with the newer value; the old value is lost.
- Reg1RD and Reg2RD may be asserted together; each acts only on its own channel.
- Every output is a direct register output; no combinational path from any input to any output.

Optional Feature:
- Macro: INPORT_OVERRUN_EN.
- Defined:
  - ovr <= 1 when an accept occurs while valid==1 and RegxRD==0.
  - ovr clears on RegxRD, unless a new overrun condition occurs on the same edge.
  - ovr is sticky otherwise.
- Undefined: Reg1_ovr and Reg2_ovr are tied to constant 0 and no overrun logic is synthesized. Ports remain present.

Test Plan:
- Reset/idle: rst=0 for 3 cycles with ext_in1=4'h7 -> all outputs 0. Release rst with ext_in1=0 held for 40 cycles -> Reg1_in=0, Reg1_valid stays 0.
- Clean change: ext_in1=4'h4, ext_in2=4'h8 held -> Reg1_in=4, Reg2_in=8, both valid=1 exactly at edge 19 after the change, not before.
- Bounce: ext_in1 toggles 4'h4/4'h5 every 5 cycles for 60 cycles, then settles at 4'h5 -> Reg1_in changes only once to 5, 19 edges after settling.
- Read/clear: pulse Reg1RD one cycle -> Reg1_valid=0 next edge, Reg1_in still 4, Reg2_valid unaffected. Reg1RD on the same edge as a new accept of 4'h9 -> Reg1_valid=1, Reg1_in=9.
- Overrun (INPORT_OVERRUN_EN defined): accept 4'h3, then 4'h6 with no read -> Reg1_in=6, Reg1_ovr=1. Reg1RD -> ovr=0 and valid=0. With the macro undefined -> Reg1_ovr=0 throughout.
- Reset mid-operation: rst=0 at cycle 10 of a debounce of 4'hA -> all outputs 0. After release with 4'hA held, acceptance occurs 19 edges after release.
